// File: rtl/dm_ext_port_pkg.sv
// dm_ext_port_pkg: shared definitions for the external data-memory port.
//   - ext_state_e      : FSM state encoding (IDLE/REQ/RELEASE/DONE)
//   - EXT_BASE_DEF     : default first address of the external window
//   - EXT_LIMIT_DEF    : default last address of the external window (inclusive)
//   - TIMEOUT_CYC_DEF  : default ack timeout in cycles
//   - to_width()       : counter width needed to count up to a cycle limit
package dm_ext_port_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_RELEASE = 2'd2,
        ST_DONE    = 2'd3
    } ext_state_e;

    localparam logic [15:0] EXT_BASE_DEF    = 16'hC000;
    localparam logic [15:0] EXT_LIMIT_DEF   = 16'hFFFF;
    localparam int          TIMEOUT_CYC_DEF = 255;

    // Bits needed to hold values 0..cyc; never narrower than one bit.
    function automatic int to_width(input int cyc);
        return (cyc < 2) ? 1 : $clog2(cyc + 1);
    endfunction

endpackage

// File: rtl/dm_ext_port_if.sv
// dm_ext_port_if: four-phase req/ack external device port.
//   master modport : driven by dm_ext_port (req, wr, add, wdata out; ack, rdata in)
//   slave modport  : the external device (ack, rdata out; req, wr, add, wdata in)
//
// Handshake: the master raises ext_req with ext_add/ext_wr/ext_wdata stable;
// the slave answers with ext_ack (ext_rdata valid while ext_ack = 1); the
// master drops ext_req; the slave drops ext_ack. A new request is only raised
// once ext_ack has been seen low.
interface dm_ext_port_if #(
    parameter int DMA_SIZE = 16,
    parameter int DMD_SIZE = 16
) ();

    logic                ext_req;
    logic                ext_wr;
    logic [DMA_SIZE-1:0] ext_add;
    logic [DMD_SIZE-1:0] ext_wdata;
    logic                ext_ack;
    logic [DMD_SIZE-1:0] ext_rdata;

    modport master (
        output ext_req, ext_wr, ext_add, ext_wdata,
        input  ext_ack, ext_rdata
    );

    modport slave (
        input  ext_req, ext_wr, ext_add, ext_wdata,
        output ext_ack, ext_rdata
    );

endinterface

// File: rtl/dm_ext_decode.sv
// dm_ext_decode: combinational window comparator for the external port.
//   cslt : core DM chip select
//   add  : DM address
//   hit  : cslt and EXT_BASE <= add <= EXT_LIMIT (unsigned, inclusive)
module dm_ext_decode #(
    parameter int                  DMA_SIZE  = 16,
    parameter logic [DMA_SIZE-1:0] EXT_BASE  = 16'hC000,
    parameter logic [DMA_SIZE-1:0] EXT_LIMIT = 16'hFFFF
) (
    input  logic                cslt,
    input  logic [DMA_SIZE-1:0] add,
    output logic                hit
);

    // Compare one bit wider so a window touching the top of the address
    // space does not turn into an always-true constant comparison.
    logic [DMA_SIZE:0] add_x;
    logic [DMA_SIZE:0] base_x;
    logic [DMA_SIZE:0] limit_x;

    assign add_x   = {1'b0, add};
    assign base_x  = {1'b0, EXT_BASE};
    assign limit_x = {1'b0, EXT_LIMIT};

    assign hit = cslt && (add_x >= base_x) && (add_x <= limit_x);

endmodule

// File: rtl/dm_ext_port.sv
// dm_ext_port: data-memory bus responder for an external address window.
// A single-cycle core DM access that hits the window is turned into a
// four-phase req/ack transaction on the external port; the core is held
// with ext_stallb = 0 until the handshake finishes, then read data is
// presented on ext_dt with ext_dt_vld for one cycle.
//
// Ports:
//   clk, reset      : core clock, synchronous active-high reset
//   ps_dm_cslt      : core DM chip select
//   ps_dm_wrb       : 1 = write, 0 = read
//   dg_dm_add       : DM address
//   bc_dt           : write data from bus connect
//   ext_stallb      : 0 = freeze core (combinational)
//   ext_dt          : read data to bus connect
//   ext_dt_vld      : ext_dt valid (DONE cycle of a read)
//   ext_err         : sticky ack-timeout flag
//   dbg_state       : current FSM state (ext_state_e encoding)
//   ext             : external device port (master side)
//
// Build option: define DM_EXT_TIMEOUT_EN to enable the ack watchdog. Without
// it the block waits indefinitely for ext_ack and ext_err is tied to 0.
module dm_ext_port
    import dm_ext_port_pkg::*;
#(
    parameter int                  DMA_SIZE    = 16,
    parameter int                  DMD_SIZE    = 16,
    parameter logic [DMA_SIZE-1:0] EXT_BASE    = EXT_BASE_DEF,
    parameter logic [DMA_SIZE-1:0] EXT_LIMIT   = EXT_LIMIT_DEF,
    parameter int                  TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ps_dm_cslt,
    input  logic                ps_dm_wrb,
    input  logic [DMA_SIZE-1:0] dg_dm_add,
    input  logic [DMD_SIZE-1:0] bc_dt,
    output logic                ext_stallb,
    output logic [DMD_SIZE-1:0] ext_dt,
    output logic                ext_dt_vld,
    output logic                ext_err,
    output logic [1:0]          dbg_state,
    dm_ext_port_if.master       ext
);

    logic hit;

    dm_ext_decode #(
        .DMA_SIZE  (DMA_SIZE),
        .EXT_BASE  (EXT_BASE),
        .EXT_LIMIT (EXT_LIMIT)
    ) u_decode (
        .cslt (ps_dm_cslt),
        .add  (dg_dm_add),
        .hit  (hit)
    );

    ext_state_e          state_q, state_d;
    logic                req_q, req_d;
    logic                wr_q, wr_d;
    logic [DMA_SIZE-1:0] add_q, add_d;
    logic [DMD_SIZE-1:0] wdata_q, wdata_d;
    logic [DMD_SIZE-1:0] dt_q, dt_d;
    logic                vld_q, vld_d;

`ifdef DM_EXT_TIMEOUT_EN
    localparam int                TO_W    = to_width(TIMEOUT_CYC);
    localparam logic [TO_W-1:0]   TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    logic [TO_W-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;
`else
    // Keeps the timeout parameter referenced when the watchdog is not built.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYC;
`endif

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        wr_d    = wr_q;
        add_d   = add_q;
        wdata_d = wdata_q;
        dt_d    = dt_q;
        vld_d   = 1'b0;
`ifdef DM_EXT_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = err_q;
`endif

        case (state_q)
            ST_IDLE: begin
                // A slave still holding ack from before must release it
                // before a new request may start.
                if (hit && !ext.ext_ack) begin
                    add_d   = dg_dm_add;
                    wr_d    = ps_dm_wrb;
                    wdata_d = bc_dt;
                    req_d   = 1'b1;
                    state_d = ST_REQ;
`ifdef DM_EXT_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end

            ST_REQ: begin
                if (ext.ext_ack) begin
                    if (!wr_q) begin
                        dt_d = ext.ext_rdata;
                    end
                    req_d   = 1'b0;
                    state_d = ST_RELEASE;
`ifdef DM_EXT_TIMEOUT_EN
                    cnt_d   = '0;
                end else if (cnt_q == TO_LAST) begin
                    err_d   = 1'b1;
                    req_d   = 1'b0;
                    if (!wr_q) begin
                        dt_d = '0;
                    end
                    vld_d   = !wr_q;
                    state_d = ST_DONE;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
`endif
                end
            end

            ST_RELEASE: begin
                if (!ext.ext_ack) begin
                    vld_d   = !wr_q;
                    state_d = ST_DONE;
`ifdef DM_EXT_TIMEOUT_EN
                end else if (cnt_q == TO_LAST) begin
                    err_d   = 1'b1;
                    if (!wr_q) begin
                        dt_d = '0;
                    end
                    vld_d   = !wr_q;
                    state_d = ST_DONE;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
`endif
                end
            end

            ST_DONE: begin
                // The core consumes the access on this edge.
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            wr_q    <= 1'b0;
            add_q   <= '0;
            wdata_q <= '0;
            dt_q    <= '0;
            vld_q   <= 1'b0;
`ifdef DM_EXT_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            wr_q    <= wr_d;
            add_q   <= add_d;
            wdata_q <= wdata_d;
            dt_q    <= dt_d;
            vld_q   <= vld_d;
`ifdef DM_EXT_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    // Stall is combinational so the core freezes in the detection cycle;
    // it is forced inactive while reset is asserted.
    always_comb begin
        ext_stallb = 1'b1;
        if (!reset) begin
            if ((state_q == ST_IDLE && hit) ||
                state_q == ST_REQ || state_q == ST_RELEASE) begin
                ext_stallb = 1'b0;
            end
        end
    end

    assign ext.ext_req   = req_q;
    assign ext.ext_wr    = wr_q;
    assign ext.ext_add   = add_q;
    assign ext.ext_wdata = wdata_q;
    assign ext_dt        = dt_q;
    assign ext_dt_vld    = vld_q;
    assign dbg_state     = state_q;

`ifdef DM_EXT_TIMEOUT_EN
    assign ext_err = err_q;
`else
    assign ext_err = 1'b0;
`endif

endmodule
